// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS-I core: opcodes, functs,
// transfer size encodings and the control FSM state type.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2
  } state_t;

  localparam logic [1:0] SZ_W = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_B = 2'b10;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [4:0] RI_BLTZ = 5'd0;
  localparam logic [4:0] RI_BGEZ = 5'd1;

endpackage

// File: rtl/mips_regfile.sv
// 32x32 general-purpose register file: two async read ports, one sync write
// port, async active-low clear; r0 is never written so it always reads 0.
module mips_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic [1023:0] mem
);

  logic [31:0] regs [32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

  for (genvar g = 0; g < 32; g++) begin : g_dump
    assign mem[32*g +: 32] = regs[g];
  end

endmodule

// File: rtl/mips_mc_core.sv
// Multi-cycle (FETCH/EXEC/MEM) big-endian MIPS-I integer core with a separate
// instruction bus and a shared bidirectional data bus.
module mips_mc_core
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] IAD,
  input  logic [XLEN-1:0] IDT,
  input  logic            ACKI_n,
  output logic [XLEN-1:0] DAD,
  inout  wire  [XLEN-1:0] DDT,
  output logic            MREQ,
  output logic            WRITE,
  output logic [1:0]      SIZE,
  input  logic            ACKD_n,
  input  logic [2:0]      OINT_n,
  output logic            IACK_n
);

  state_t      state;
  logic [31:0] pc, npc, ir, sdata;

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] simm, zimm, rs_val, rt_val, br_tgt;

  logic        alu_we, taken, jump, is_ld, is_st;
  logic [4:0]  alu_wa;
  logic [31:0] alu_res, jtgt, next_npc, ld_data, ea, st_data;
  logic [1:0]  mem_size;

  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [1023:0] rf_dump_unused;
  logic        ints_unused;

  assign op     = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign shamt  = ir[10:6];
  assign fn     = ir[5:0];
  assign imm    = ir[15:0];
  assign simm   = {{16{imm[15]}}, imm};
  assign zimm   = {16'h0000, imm};
  assign br_tgt = npc + {simm[29:0], 2'b00};
  assign ea     = rs_val + simm;

  mips_regfile u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (rf_we),
    .waddr  (rf_wa),
    .wdata  (rf_wd),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rs_val),
    .rdata2 (rt_val),
    .mem    (rf_dump_unused)
  );

  always_comb begin
    alu_we   = 1'b0;
    alu_wa   = rd;
    alu_res  = '0;
    taken    = 1'b0;
    jump     = 1'b0;
    jtgt     = '0;
    is_ld    = 1'b0;
    is_st    = 1'b0;
    mem_size = SZ_W;
    case (op)
      OP_SPECIAL: begin
        alu_we = 1'b1;
        case (fn)
          FN_SLL:  alu_res = rt_val << shamt;
          FN_SRL:  alu_res = rt_val >> shamt;
          FN_SRA:  alu_res = $signed(rt_val) >>> shamt;
          FN_SLLV: alu_res = rt_val << rs_val[4:0];
          FN_SRLV: alu_res = rt_val >> rs_val[4:0];
          FN_SRAV: alu_res = $signed(rt_val) >>> rs_val[4:0];
          FN_ADD, FN_ADDU: alu_res = rs_val + rt_val;
          FN_SUB, FN_SUBU: alu_res = rs_val - rt_val;
          FN_AND:  alu_res = rs_val & rt_val;
          FN_OR:   alu_res = rs_val | rt_val;
          FN_XOR:  alu_res = rs_val ^ rt_val;
          FN_NOR:  alu_res = ~(rs_val | rt_val);
          FN_SLT:  alu_res = {31'd0, $signed(rs_val) < $signed(rt_val)};
          FN_SLTU: alu_res = {31'd0, rs_val < rt_val};
          FN_JR: begin
            alu_we = 1'b0;
            jump   = 1'b1;
            jtgt   = rs_val;
          end
          FN_JALR: begin
            jump    = 1'b1;
            jtgt    = rs_val;
            alu_res = pc + 32'd8;
          end
          default: alu_we = 1'b0;
        endcase
      end
      OP_REGIMM: begin
        if (rt == RI_BLTZ) taken = rs_val[31];
        if (rt == RI_BGEZ) taken = ~rs_val[31];
      end
      OP_J: begin
        jump = 1'b1;
        jtgt = {npc[31:28], ir[25:0], 2'b00};
      end
      OP_JAL: begin
        jump    = 1'b1;
        jtgt    = {npc[31:28], ir[25:0], 2'b00};
        alu_we  = 1'b1;
        alu_wa  = 5'd31;
        alu_res = pc + 32'd8;
      end
      OP_BEQ:  taken = (rs_val == rt_val);
      OP_BNE:  taken = (rs_val != rt_val);
      OP_BLEZ: taken = rs_val[31] | (rs_val == 32'd0);
      OP_BGTZ: taken = ~rs_val[31] & (rs_val != 32'd0);
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        alu_we = 1'b1;
        alu_wa = rt;
        case (op)
          OP_SLTI:  alu_res = {31'd0, $signed(rs_val) < $signed(simm)};
          OP_SLTIU: alu_res = {31'd0, rs_val < simm};
          OP_ANDI:  alu_res = rs_val & zimm;
          OP_ORI:   alu_res = rs_val | zimm;
          OP_XORI:  alu_res = rs_val ^ zimm;
          OP_LUI:   alu_res = {imm, 16'h0000};
          default:  alu_res = rs_val + simm;
        endcase
      end
      OP_LB, OP_LBU: begin is_ld = 1'b1; mem_size = SZ_B; end
      OP_LH, OP_LHU: begin is_ld = 1'b1; mem_size = SZ_H; end
      OP_LW:         begin is_ld = 1'b1; mem_size = SZ_W; end
      OP_SB:         begin is_st = 1'b1; mem_size = SZ_B; end
      OP_SH:         begin is_st = 1'b1; mem_size = SZ_H; end
      OP_SW:         begin is_st = 1'b1; mem_size = SZ_W; end
      default: ;
    endcase
  end

  assign next_npc = jump ? jtgt : (taken ? br_tgt : npc + 32'd4);

  always_comb begin
    case (op)
      OP_LB:   ld_data = {{24{DDT[7]}}, DDT[7:0]};
      OP_LBU:  ld_data = {24'd0, DDT[7:0]};
      OP_LH:   ld_data = {{16{DDT[15]}}, DDT[15:0]};
      OP_LHU:  ld_data = {16'd0, DDT[15:0]};
      default: ld_data = DDT;
    endcase
  end

  always_comb begin
    case (mem_size)
      SZ_B:    st_data = {24'd0, rt_val[7:0]};
      SZ_H:    st_data = {16'd0, rt_val[15:0]};
      default: st_data = rt_val;
    endcase
  end

  // Two write sources share the single port: ALU results in EXEC, load data
  // on the acknowledging edge of MEM (IR still holds the load instruction).
  always_comb begin
    if (state == ST_MEM) begin
      rf_we = is_ld && !ACKD_n;
      rf_wa = rt;
      rf_wd = ld_data;
    end else begin
      rf_we = (state == ST_EXEC) && alu_we;
      rf_wa = alu_wa;
      rf_wd = alu_res;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_FETCH;
      pc    <= RESET_PC;
      npc   <= RESET_PC + 32'd4;
      ir    <= '0;
      DAD   <= '0;
      MREQ  <= 1'b0;
      WRITE <= 1'b0;
      SIZE  <= SZ_W;
      sdata <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (!ACKI_n) begin
            ir    <= IDT;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          pc  <= npc;
          npc <= next_npc;
          if (is_ld || is_st) begin
            DAD   <= ea;
            SIZE  <= mem_size;
            WRITE <= is_st;
            MREQ  <= 1'b1;
            sdata <= st_data;
            state <= ST_MEM;
          end else begin
            state <= ST_FETCH;
          end
        end
        ST_MEM: begin
          if (!ACKD_n) begin
            MREQ  <= 1'b0;
            WRITE <= 1'b0;
            state <= ST_FETCH;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

  assign IAD    = pc;
  assign DDT    = (MREQ && WRITE) ? sdata : 'z;
  assign IACK_n = 1'b1;
  assign ints_unused = ^OINT_n;

endmodule

// File: tb/tb_mips_mc_core.sv
// Directed bench for mips_mc_core: small programs in a bench IMEM, a
// scripted data responder, register-file inspection through the dump vector.
module tb_mips_mc_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ACKI_n = 1'b0;
  logic        ACKD_n = 1'b0;
  logic [2:0]  OINT_n = 3'b111;
  logic [31:0] load_val = '0;
  logic [31:0] imem [64];

  logic [31:0] IAD, IDT, DAD;
  wire  [31:0] DDT;
  logic        MREQ, WRITE, IACK_n;
  logic [1:0]  SIZE;

  int checks = 0;
  int errors = 0;

  int          st_cyc = 0;
  logic [31:0] st_dad, st_ddt;
  logic [1:0]  st_size;

  mips_mc_core #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .IAD(IAD), .IDT(IDT), .ACKI_n(ACKI_n),
    .DAD(DAD), .DDT(DDT), .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE),
    .ACKD_n(ACKD_n), .OINT_n(OINT_n), .IACK_n(IACK_n)
  );

  always #5 clk = ~clk;

  assign IDT = imem[IAD[7:2]];
  assign DDT = (MREQ && !WRITE) ? load_val : 'z;

  always @(negedge clk) begin
    if (rst && MREQ && WRITE) begin
      st_cyc  <= st_cyc + 1;
      st_dad  <= DAD;
      st_ddt  <= DDT;
      st_size <= SIZE;
    end
  end

  function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] er(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [4:0] sh,
                                     input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] ej(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  function automatic logic [31:0] rf(input int n);
    return dut.u_rf.mem[n*32 +: 32];
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    st_cyc = 0;
    cycles(2);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clear_imem();
    imem[0] = ei(6'h0d, 5'd0, 5'd1, 16'h1234);
    ACKI_n = 1'b1;
    rst = 1'b0;
    #3;
    checks++; if (IAD !== 32'h0) begin errors++; $display("FAIL reset_iad got %h exp %h", IAD, 32'h0); end
    checks++; if (DAD !== 32'h0) begin errors++; $display("FAIL reset_dad got %h exp %h", DAD, 32'h0); end
    checks++; if ({MREQ, WRITE, SIZE, IACK_n} !== 5'b00001) begin errors++; $display("FAIL reset_ctl got %b exp %b", {MREQ, WRITE, SIZE, IACK_n}, 5'b00001); end
    checks++; if (rf(31) !== 32'h0) begin errors++; $display("FAIL reset_r31 got %h exp %h", rf(31), 32'h0); end
  endtask

  task automatic test_fetch_stall();
    ACKI_n = 1'b1;
    do_reset();
    cycles(3);
    checks++; if (IAD !== 32'h0) begin errors++; $display("FAIL stall_iad got %h exp %h", IAD, 32'h0); end
    checks++; if (rf(1) !== 32'h0) begin errors++; $display("FAIL stall_r1 got %h exp %h", rf(1), 32'h0); end
    ACKI_n = 1'b0;
    cycles(2);
    checks++; if (rf(1) !== 32'h1234) begin errors++; $display("FAIL stall_r1_after got %h exp %h", rf(1), 32'h1234); end
    checks++; if (IAD !== 32'h4) begin errors++; $display("FAIL stall_iad_after got %h exp %h", IAD, 32'h4); end
  endtask

  task automatic test_alu();
    clear_imem();
    imem[0] = ei(6'h0d, 5'd0, 5'd1, 16'h1234);
    imem[1] = ei(6'h09, 5'd1, 5'd2, 16'hfffc);
    imem[2] = ei(6'h0d, 5'd0, 5'd0, 16'h0055);
    imem[3] = er(5'd0, 5'd1, 5'd14, 5'd0, 6'h21);
    ACKI_n = 1'b0;
    do_reset();
    cycles(1);
    checks++; if (IAD !== 32'h0) begin errors++; $display("FAIL alu_iad0 got %h exp %h", IAD, 32'h0); end
    cycles(1);
    checks++; if (IAD !== 32'h4) begin errors++; $display("FAIL alu_iad4 got %h exp %h", IAD, 32'h4); end
    checks++; if (rf(1) !== 32'h1234) begin errors++; $display("FAIL alu_ori got %h exp %h", rf(1), 32'h1234); end
    cycles(2);
    checks++; if (IAD !== 32'h8) begin errors++; $display("FAIL alu_iad8 got %h exp %h", IAD, 32'h8); end
    checks++; if (rf(2) !== 32'h1230) begin errors++; $display("FAIL alu_addiu got %h exp %h", rf(2), 32'h1230); end
    cycles(4);
    checks++; if (rf(0) !== 32'h0) begin errors++; $display("FAIL alu_r0 got %h exp %h", rf(0), 32'h0); end
    checks++; if (rf(14) !== 32'h1234) begin errors++; $display("FAIL alu_addu got %h exp %h", rf(14), 32'h1234); end
  endtask

  task automatic test_alu_misc();
    clear_imem();
    imem[0] = ei(6'h0f, 5'd0, 5'd1, 16'h8000);
    imem[1] = er(5'd0, 5'd1, 5'd2, 5'd4, 6'h03);
    imem[2] = ei(6'h0b, 5'd0, 5'd3, 16'hffff);
    imem[3] = er(5'd1, 5'd0, 5'd4, 5'd0, 6'h2a);
    imem[4] = er(5'd0, 5'd0, 5'd5, 5'd0, 6'h27);
    do_reset();
    cycles(10);
    checks++; if (rf(2) !== 32'hf800_0000) begin errors++; $display("FAIL misc_sra got %h exp %h", rf(2), 32'hf800_0000); end
    checks++; if (rf(3) !== 32'h1) begin errors++; $display("FAIL misc_sltiu got %h exp %h", rf(3), 32'h1); end
    checks++; if (rf(4) !== 32'h1) begin errors++; $display("FAIL misc_slt got %h exp %h", rf(4), 32'h1); end
    checks++; if (rf(5) !== 32'hffff_ffff) begin errors++; $display("FAIL misc_nor got %h exp %h", rf(5), 32'hffff_ffff); end
  endtask

  task automatic test_load_store();
    clear_imem();
    imem[0] = ei(6'h0d, 5'd0, 5'd2, 16'h1230);
    imem[1] = ei(6'h0f, 5'd0, 5'd3, 16'h8000);
    imem[2] = ei(6'h2b, 5'd3, 5'd2, 16'h0000);
    imem[3] = ei(6'h23, 5'd3, 5'd4, 16'h0000);
    load_val = 32'h0000_1230;
    ACKD_n = 1'b0;
    do_reset();
    cycles(12);
    checks++; if (st_cyc !== 1) begin errors++; $display("FAIL ls_store_cycles got %0d exp %0d", st_cyc, 1); end
    checks++; if (st_dad !== 32'h8000_0000) begin errors++; $display("FAIL ls_store_dad got %h exp %h", st_dad, 32'h8000_0000); end
    checks++; if (st_size !== 2'b00) begin errors++; $display("FAIL ls_store_size got %b exp %b", st_size, 2'b00); end
    checks++; if (st_ddt !== 32'h0000_1230) begin errors++; $display("FAIL ls_store_ddt got %h exp %h", st_ddt, 32'h0000_1230); end
    checks++; if (rf(4) !== 32'h1230) begin errors++; $display("FAIL ls_lw got %h exp %h", rf(4), 32'h1230); end
  endtask

  task automatic test_load_ext();
    clear_imem();
    imem[0] = ei(6'h0f, 5'd0, 5'd3, 16'h8000);
    imem[1] = ei(6'h20, 5'd3, 5'd6, 16'h0003);
    imem[2] = ei(6'h24, 5'd3, 5'd7, 16'h0003);
    load_val = 32'h0000_0080;
    do_reset();
    cycles(4);
    checks++; if ({MREQ, WRITE, SIZE} !== 4'b1010) begin errors++; $display("FAIL lb_ctl got %b exp %b", {MREQ, WRITE, SIZE}, 4'b1010); end
    checks++; if (DAD !== 32'h8000_0003) begin errors++; $display("FAIL lb_dad got %h exp %h", DAD, 32'h8000_0003); end
    cycles(6);
    checks++; if (rf(6) !== 32'hffff_ff80) begin errors++; $display("FAIL lb_sext got %h exp %h", rf(6), 32'hffff_ff80); end
    checks++; if (rf(7) !== 32'h0000_0080) begin errors++; $display("FAIL lbu_zext got %h exp %h", rf(7), 32'h0000_0080); end
  endtask

  task automatic test_branch();
    clear_imem();
    imem[0] = ei(6'h04, 5'd0, 5'd0, 16'h0002);
    imem[1] = ei(6'h09, 5'd0, 5'd5, 16'h0001);
    imem[2] = ei(6'h09, 5'd0, 5'd9, 16'h0007);
    imem[3] = ei(6'h0d, 5'd0, 5'd10, 16'h0005);
    do_reset();
    cycles(2);
    checks++; if (IAD !== 32'h4) begin errors++; $display("FAIL br_slot_iad got %h exp %h", IAD, 32'h4); end
    cycles(2);
    checks++; if (IAD !== 32'hc) begin errors++; $display("FAIL br_target_iad got %h exp %h", IAD, 32'hc); end
    cycles(4);
    checks++; if (rf(5) !== 32'h1) begin errors++; $display("FAIL br_delay_slot got %h exp %h", rf(5), 32'h1); end
    checks++; if (rf(9) !== 32'h0) begin errors++; $display("FAIL br_skipped got %h exp %h", rf(9), 32'h0); end
    checks++; if (rf(10) !== 32'h5) begin errors++; $display("FAIL br_target got %h exp %h", rf(10), 32'h5); end
  endtask

  task automatic test_jal();
    clear_imem();
    imem[0]  = ej(6'h02, 26'h10);
    imem[16] = ej(6'h03, 26'h20);
    imem[17] = ei(6'h0d, 5'd0, 5'd11, 16'h0011);
    imem[18] = ei(6'h0d, 5'd0, 5'd13, 16'h0033);
    imem[32] = ei(6'h0d, 5'd0, 5'd12, 16'h0022);
    do_reset();
    cycles(6);
    checks++; if (IAD !== 32'h44) begin errors++; $display("FAIL jal_slot_iad got %h exp %h", IAD, 32'h44); end
    cycles(2);
    checks++; if (IAD !== 32'h80) begin errors++; $display("FAIL jal_target_iad got %h exp %h", IAD, 32'h80); end
    cycles(2);
    checks++; if (rf(31) !== 32'h48) begin errors++; $display("FAIL jal_link got %h exp %h", rf(31), 32'h48); end
    checks++; if (rf(11) !== 32'h11) begin errors++; $display("FAIL jal_delay got %h exp %h", rf(11), 32'h11); end
    checks++; if (rf(12) !== 32'h22) begin errors++; $display("FAIL jal_target got %h exp %h", rf(12), 32'h22); end
    checks++; if (rf(13) !== 32'h0) begin errors++; $display("FAIL jal_skipped got %h exp %h", rf(13), 32'h0); end
  endtask

  task automatic load_sb_prog();
    clear_imem();
    imem[0] = ei(6'h0f, 5'd0, 5'd3, 16'hf000);
    imem[1] = ei(6'h0d, 5'd0, 5'd1, 16'h0041);
    imem[2] = ei(6'h28, 5'd3, 5'd1, 16'h0000);
  endtask

  task automatic test_sb_console();
    load_sb_prog();
    ACKD_n = 1'b1;
    do_reset();
    cycles(6);
    checks++; if ({MREQ, WRITE, SIZE} !== 4'b1110) begin errors++; $display("FAIL sb_ctl got %b exp %b", {MREQ, WRITE, SIZE}, 4'b1110); end
    checks++; if (DAD !== 32'hf000_0000) begin errors++; $display("FAIL sb_dad got %h exp %h", DAD, 32'hf000_0000); end
    checks++; if (DDT !== 32'h0000_0041) begin errors++; $display("FAIL sb_ddt got %h exp %h", DDT, 32'h0000_0041); end
    cycles(2);
    checks++; if ({MREQ, WRITE, DDT} !== {2'b11, 32'h41}) begin errors++; $display("FAIL sb_hold got %b/%h exp 11/%h", {MREQ, WRITE}, DDT, 32'h41); end
    ACKD_n = 1'b0;
    cycles(1);
    checks++; if ({MREQ, WRITE} !== 2'b00) begin errors++; $display("FAIL sb_release got %b exp %b", {MREQ, WRITE}, 2'b00); end
    checks++; if (IAD !== 32'hc) begin errors++; $display("FAIL sb_next_iad got %h exp %h", IAD, 32'hc); end
  endtask

  task automatic test_reset_mid_access();
    load_sb_prog();
    ACKD_n = 1'b1;
    do_reset();
    cycles(6);
    #2 rst = 1'b0;
    #1;
    checks++; if ({MREQ, WRITE} !== 2'b00) begin errors++; $display("FAIL midrst_ctl got %b exp %b", {MREQ, WRITE}, 2'b00); end
    checks++; if (IAD !== 32'h0) begin errors++; $display("FAIL midrst_iad got %h exp %h", IAD, 32'h0); end
    ACKD_n = 1'b0;
    cycles(1);
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fetch_stall();
    test_alu();
    test_alu_misc();
    test_load_store();
    test_load_ext();
    test_branch();
    test_jal();
    test_sb_console();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
